// File: rtl/fir_power_ctrl.sv
// Power sequencer for a power-gated FIR core: gates power_enable after idle periods,
// wakes on traffic, and steps a 2-bit performance level from per-window input throughput.
module fir_power_ctrl #(
  parameter int unsigned IDLE_TIMEOUT = 64,
  parameter int unsigned WAKE_CYCLES  = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned WINDOW       = 256,
  parameter int unsigned THR_MED      = 64,
  parameter int unsigned THR_HIGH     = 128,
  parameter int unsigned THR_MAX      = 192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_axis_fir_tvalid,
  output logic       s_axis_fir_tready,
  input  logic       fir_s_tready,
  input  logic       force_on,
  output logic       power_enable,
  output logic [1:0] performance_level,
  output logic [1:0] ctrl_state
);

  localparam int unsigned WakeW  = $clog2(WAKE_CYCLES + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned IdleW  = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned WinW   = $clog2(WINDOW);
  localparam int unsigned BeatW  = $clog2(WINDOW + 1);

  localparam logic [WakeW-1:0]  WakeLoad  = WakeW'(WAKE_CYCLES - 1);
  localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);
  localparam logic [IdleW-1:0]  IdleLast  = IdleW'(IDLE_TIMEOUT - 1);
  localparam logic [WinW-1:0]   WinLast   = WinW'(WINDOW - 1);
  localparam logic [BeatW-1:0]  BeatMax   = BeatW'(WINDOW);
  localparam logic [BeatW-1:0]  ThrMed    = BeatW'(THR_MED);
  localparam logic [BeatW-1:0]  ThrHigh   = BeatW'(THR_HIGH);
  localparam logic [BeatW-1:0]  ThrMax    = BeatW'(THR_MAX);

  typedef enum logic [1:0] {
    StOff   = 2'b00,
    StWake  = 2'b01,
    StOn    = 2'b10,
    StDrain = 2'b11
  } state_e;

  state_e             r_state;
  logic               r_pwr;
  logic [1:0]         r_level;
  logic [WakeW-1:0]   r_wake_cnt;
  logic [DrainW-1:0]  r_drain_cnt;
  logic [IdleW-1:0]   r_idle_cnt;
  logic [WinW-1:0]    r_win_cnt;
  logic [BeatW-1:0]   r_beat_cnt;

  logic               w_accept;
  logic               w_wake_req;
  logic               w_win_last;
  logic [BeatW-1:0]   w_beat_next;
  logic [1:0]         w_target;
  logic [1:0]         w_level_next;

  assign s_axis_fir_tready = fir_s_tready && (r_state == StOn);
  assign w_accept          = s_axis_fir_tvalid && s_axis_fir_tready;
  assign w_wake_req        = s_axis_fir_tvalid || force_on;
  assign w_win_last        = (r_win_cnt == WinLast);

  assign power_enable      = r_pwr;
  assign performance_level = r_level;
  assign ctrl_state        = r_state;

  // Beat count including this cycle's beat, so the last window cycle is counted.
  always_comb begin
    w_beat_next = r_beat_cnt;
    if (w_accept && (r_beat_cnt != BeatMax)) begin
      w_beat_next = r_beat_cnt + BeatW'(1);
    end

    if (w_beat_next >= ThrMax) begin
      w_target = 2'b11;
    end else if (w_beat_next >= ThrHigh) begin
      w_target = 2'b10;
    end else if (w_beat_next >= ThrMed) begin
      w_target = 2'b01;
    end else begin
      w_target = 2'b00;
    end

    w_level_next = r_level;
    if (w_target > r_level) begin
      w_level_next = r_level + 2'd1;
    end else if (w_target < r_level) begin
      w_level_next = r_level - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StOff;
      r_pwr       <= 1'b0;
      r_level     <= 2'b00;
      r_wake_cnt  <= '0;
      r_drain_cnt <= '0;
      r_idle_cnt  <= '0;
      r_win_cnt   <= '0;
      r_beat_cnt  <= '0;
    end else begin
      case (r_state)
        StOff: begin
          if (w_wake_req) begin
            r_state    <= StWake;
            r_pwr      <= 1'b1;
            r_wake_cnt <= WakeLoad;
          end
        end

        StWake: begin
          if (r_wake_cnt == '0) begin
            r_state    <= StOn;
            r_idle_cnt <= '0;
          end else begin
            r_wake_cnt <= r_wake_cnt - WakeW'(1);
          end
        end

        StOn: begin
          if (w_win_last) begin
            r_level    <= w_level_next;
            r_win_cnt  <= '0;
            r_beat_cnt <= '0;
          end else begin
            r_win_cnt  <= r_win_cnt + WinW'(1);
            r_beat_cnt <= w_beat_next;
          end

          if (w_accept || force_on) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == IdleLast) begin
            // This idle edge is the IDLE_TIMEOUT-th one.
            r_state     <= StDrain;
            r_drain_cnt <= DrainLoad;
          end else begin
            r_idle_cnt <= r_idle_cnt + IdleW'(1);
          end
        end

        StDrain: begin
          if (w_wake_req) begin
            r_state    <= StOn;
            r_idle_cnt <= '0;
          end else if (r_drain_cnt == '0) begin
            r_state    <= StOff;
            r_pwr      <= 1'b0;
            r_level    <= 2'b00;
            r_win_cnt  <= '0;
            r_beat_cnt <= '0;
          end else begin
            r_drain_cnt <= r_drain_cnt - DrainW'(1);
          end
        end

        default: begin
          r_state <= StOff;
          r_pwr   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_power_ctrl.sv
// Randomised plus directed bench for fir_power_ctrl, checked each cycle against a
// timestamp-based behavioural model through an expectation queue.
module tb_fir_power_ctrl;

  localparam int IdleTo = 64;
  localparam int WakeC  = 4;
  localparam int DrainC = 3;
  localparam int Win    = 256;
  localparam int TMed   = 64;
  localparam int THigh  = 128;
  localparam int TMax   = 192;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tvalid = 1'b0;
  logic       tready;
  logic       frdy = 1'b0;
  logic       force_on = 1'b0;
  logic       pe;
  logic [1:0] level;
  logic [1:0] cstate;

  always #5 clk = ~clk;

  fir_power_ctrl #(
    .IDLE_TIMEOUT(IdleTo),
    .WAKE_CYCLES (WakeC),
    .DRAIN_CYCLES(DrainC),
    .WINDOW      (Win),
    .THR_MED     (TMed),
    .THR_HIGH    (THigh),
    .THR_MAX     (TMax)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .s_axis_fir_tvalid(tvalid),
    .s_axis_fir_tready(tready),
    .fir_s_tready     (frdy),
    .force_on         (force_on),
    .power_enable     (pe),
    .performance_level(level),
    .ctrl_state       (cstate)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       pe;
    logic [1:0] lvl;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model: mode 0 OFF, 1 WAKE, 2 ON, 3 DRAIN; deadlines kept as absolute edge numbers.
  int cyc = 0;
  int m_mode = 0;
  int m_pe = 0;
  int m_level = 0;
  int on_at = 0;
  int off_at = 0;
  int last_busy = 0;
  int win_pos = 0;
  int win_beats = 0;

  function automatic int target_of(input int n);
    return int'(n >= TMax) + int'(n >= THigh) + int'(n >= TMed);
  endfunction

  task automatic model_step();
    bit acc;
    int t;
    cyc++;
    acc = tvalid && frdy && (m_mode == 2);
    if (reset) begin
      m_mode = 0; m_pe = 0; m_level = 0; win_pos = 0; win_beats = 0;
      return;
    end
    case (m_mode)
      0: if (tvalid || force_on) begin
        m_mode = 1; m_pe = 1; on_at = cyc + WakeC;
      end
      1: if (cyc == on_at) begin
        m_mode = 2; last_busy = cyc;
      end
      2: begin
        win_beats += int'(acc);
        win_pos++;
        if (win_pos == Win) begin
          t = target_of(win_beats);
          if (t > m_level) m_level++;
          else if (t < m_level) m_level--;
          win_pos = 0;
          win_beats = 0;
        end
        if (acc || force_on) last_busy = cyc;
        else if (cyc - last_busy == IdleTo) begin
          m_mode = 3; off_at = cyc + DrainC;
        end
      end
      default: begin
        if (tvalid || force_on) begin
          m_mode = 2; last_busy = cyc;
        end else if (cyc == off_at) begin
          m_mode = 0; m_pe = 0; m_level = 0; win_pos = 0; win_beats = 0;
        end
      end
    endcase
  endtask

  task automatic cycle(input bit v, input bit f, input bit r, input bit rst);
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    tvalid = v; force_on = f; frdy = r; reset = rst;
    e.st  = 2'(m_mode);
    e.pe  = (m_pe != 0);
    e.lvl = 2'(m_level);
    e.rdy = r && (m_mode == 2);
    sb.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a full output set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks += 4;
        if (cstate !== e.st) begin
          errors++;
          $display("FAIL ctrl_state t=%0t got %0d want %0d", $time, cstate, e.st);
        end
        if (pe !== e.pe) begin
          errors++;
          $display("FAIL power_enable t=%0t got %0b want %0b", $time, pe, e.pe);
        end
        if (level !== e.lvl) begin
          errors++;
          $display("FAIL performance_level t=%0t got %0d want %0d", $time, level, e.lvl);
        end
        if (tready !== e.rdy) begin
          errors++;
          $display("FAIL s_axis_fir_tready t=%0t got %0b want %0b", $time, tready, e.rdy);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int vprob;
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    repeat (100) cycle(0, 0, 1, 0);
    // Wake on held valid, stream beats, then idle down to OFF.
    repeat (15) cycle(1, 0, 1, 0);
    repeat (75) cycle(0, 0, 1, 0);
    // Valid appears in the second DRAIN cycle.
    repeat (8) cycle(1, 0, 1, 0);
    repeat (65) cycle(0, 0, 1, 0);
    repeat (5) cycle(1, 0, 1, 0);
    // Level stepping: 200 then 10 beats per 256 cycles, kept ON by force_on.
    for (int i = 0; i < 4 * Win + 20; i++) cycle((i % Win) < 200, 1, 1, 0);
    for (int i = 0; i < 3 * Win + 20; i++) cycle((i % Win) < 10, 1, 1, 0);
    repeat (1000) cycle(0, 1, 1, 0);
    repeat (80) cycle(0, 0, 1, 0);
    // Reset while in WAKE.
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 1);
    repeat (3) cycle(0, 0, 1, 0);
    // Random traffic with changing density and occasional reset.
    for (int blk = 0; blk < 12; blk++) begin
      vprob = $urandom_range(0, 100);
      for (int i = 0; i < 500; i++) begin
        cycle($urandom_range(0, 99) < vprob, $urandom_range(0, 99) < 4,
              $urandom_range(0, 99) < 80, $urandom_range(0, 799) == 0);
      end
    end
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
